// File: rtl/rename_ctrl.sv
// Rename-stage sequencer: accepts decoded instructions, drives the alias-table ports and
// registers the renamed result toward dispatch. Define RENAME_STALL_CNT_EN for stall_cycles.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

module rename_ctrl #(
   parameter int unsigned ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
   parameter int unsigned PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
   parameter int unsigned TAG_WIDTH              = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              dec_valid,
   output logic                              dec_ready,
   input  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rs1,
   input  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rs2,
   input  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rd,
   input  logic                              dec_wr,
   input  logic [TAG_WIDTH-1:0]              dec_tag,
   output logic [ARCH_REG_NUM_WIDTH-1:0]     rat_read_reg_num1,
   output logic [ARCH_REG_NUM_WIDTH-1:0]     rat_read_reg_num2,
   output logic [ARCH_REG_NUM_WIDTH-1:0]     rat_write_reg_num,
   output logic                              rat_regwrite,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rat_phy_read1,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rat_phy_read2,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rat_phy_write,
   input  logic                              rat_valid,
   output logic                              dsp_valid,
   input  logic                              dsp_ready,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prs1,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prs2,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prd,
   output logic                              dsp_wr,
   output logic [TAG_WIDTH-1:0]              dsp_tag,
   output logic [1:0]                        state
`ifdef RENAME_STALL_CNT_EN
   ,
   output logic [31:0]                       stall_cycles
`endif
);

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStall = 2'd1,
      StFlush = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   eff_wr;
   logic   slot_free;
   logic   accept;

   // Reset gates acceptance so no allocation can escape while reset is held.
   always_comb begin
      eff_wr    = dec_wr && (dec_rd != '0);
      slot_free = !dsp_valid || dsp_ready;
      dec_ready = (state_q == StRun) && !flush && !reset && slot_free && (!eff_wr || rat_valid);
      accept    = dec_valid && dec_ready;
   end

   assign rat_regwrite      = accept && eff_wr;
   assign rat_read_reg_num1 = dec_rs1;
   assign rat_read_reg_num2 = dec_rs2;
   assign rat_write_reg_num = dec_rd;
   assign state             = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:   if (dec_valid && eff_wr && !rat_valid) state_d = StStall;
         StStall: if (rat_valid) state_d = StRun;
         StFlush: state_d = StRun;
         default: state_d = StRun;
      endcase
      if (flush) state_d = StFlush;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StRun;
         dsp_valid <= 1'b0;
         dsp_prs1  <= '0;
         dsp_prs2  <= '0;
         dsp_prd   <= '0;
         dsp_wr    <= 1'b0;
         dsp_tag   <= '0;
      end else begin
         state_q <= state_d;
         if (flush) begin
            dsp_valid <= 1'b0;
         end else if (accept) begin
            dsp_valid <= 1'b1;
            dsp_prs1  <= rat_phy_read1;
            dsp_prs2  <= rat_phy_read2;
            dsp_prd   <= eff_wr ? rat_phy_write : '0;
            dsp_wr    <= eff_wr;
            dsp_tag   <= dec_tag;
         end else if (dsp_ready) begin
            dsp_valid <= 1'b0;
         end
      end
   end

`ifdef RENAME_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (dec_valid && !dec_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: per-cycle model comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_rename_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       dec_valid = 1'b0;
   logic       dec_ready;
   logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
   logic       dec_wr = 1'b0;
   logic [7:0] dec_tag = '0;
   logic [4:0] rat_read_reg_num1, rat_read_reg_num2, rat_write_reg_num;
   logic       rat_regwrite;
   logic [5:0] rat_phy_read1 = '0, rat_phy_read2 = '0, rat_phy_write = '0;
   logic       rat_valid = 1'b0;
   logic       dsp_valid;
   logic       dsp_ready = 1'b0;
   logic [5:0] dsp_prs1, dsp_prs2, dsp_prd;
   logic       dsp_wr;
   logic [7:0] dsp_tag;
   logic [1:0] state;
`ifdef RENAME_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int rst_pulses = 0;
   int rst_seen = 0;

   rename_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .dec_valid         (dec_valid),
      .dec_ready         (dec_ready),
      .dec_rs1           (dec_rs1),
      .dec_rs2           (dec_rs2),
      .dec_rd            (dec_rd),
      .dec_wr            (dec_wr),
      .dec_tag           (dec_tag),
      .rat_read_reg_num1 (rat_read_reg_num1),
      .rat_read_reg_num2 (rat_read_reg_num2),
      .rat_write_reg_num (rat_write_reg_num),
      .rat_regwrite      (rat_regwrite),
      .rat_phy_read1     (rat_phy_read1),
      .rat_phy_read2     (rat_phy_read2),
      .rat_phy_write     (rat_phy_write),
      .rat_valid         (rat_valid),
      .dsp_valid         (dsp_valid),
      .dsp_ready         (dsp_ready),
      .dsp_prs1          (dsp_prs1),
      .dsp_prs2          (dsp_prs2),
      .dsp_prd           (dsp_prd),
      .dsp_wr            (dsp_wr),
      .dsp_tag           (dsp_tag),
      .state             (state)
`ifdef RENAME_STALL_CNT_EN
      ,
      .stall_cycles      (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the held dispatch slot, the sequencer mode (0 run, 1 stall, 2 flush), stall count.
   logic        m_valid, m_wr;
   logic [5:0]  m_prs1, m_prs2, m_prd;
   logic [7:0]  m_tag;
   int          m_mode;
   logic [31:0] m_stall;
   logic        m_ewr, m_room, m_ready, m_take;

   always @(negedge clk) begin
      if (reset || (rst_pulses != rst_seen)) begin
         rst_seen = rst_pulses;
         m_valid = 1'b0; m_wr = 1'b0; m_prs1 = '0; m_prs2 = '0; m_prd = '0; m_tag = '0;
         m_mode = 0; m_stall = '0;
      end
      m_ewr   = dec_wr && (dec_rd != 5'd0);
      m_room  = !m_valid || dsp_ready;
      m_ready = !reset && (m_mode == 0) && !flush && m_room && (!m_ewr || rat_valid);
      m_take  = dec_valid && m_ready;

      check("dec_ready", 32'(dec_ready), 32'(m_ready));
      check("rat_regwrite", 32'(rat_regwrite), 32'(m_take && m_ewr));
      check("rat_read_reg_num1", 32'(rat_read_reg_num1), 32'(dec_rs1));
      check("rat_read_reg_num2", 32'(rat_read_reg_num2), 32'(dec_rs2));
      check("rat_write_reg_num", 32'(rat_write_reg_num), 32'(dec_rd));
      check("dsp_valid", 32'(dsp_valid), 32'(m_valid));
      check("dsp_prs1", 32'(dsp_prs1), 32'(m_prs1));
      check("dsp_prs2", 32'(dsp_prs2), 32'(m_prs2));
      check("dsp_prd", 32'(dsp_prd), 32'(m_prd));
      check("dsp_wr", 32'(dsp_wr), 32'(m_wr));
      check("dsp_tag", 32'(dsp_tag), 32'(m_tag));
      check("state", 32'(state), 32'(m_mode));
`ifdef RENAME_STALL_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif

      if (!reset) begin
         if (dec_valid && !m_ready && !flush && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
         if (flush) begin
            m_valid = 1'b0;
            m_mode  = 2;
         end else begin
            if (m_take) begin
               m_valid = 1'b1;
               m_prs1  = rat_phy_read1;
               m_prs2  = rat_phy_read2;
               m_prd   = m_ewr ? rat_phy_write : 6'd0;
               m_wr    = m_ewr;
               m_tag   = dec_tag;
            end else if (dsp_ready) begin
               m_valid = 1'b0;
            end
            if (m_mode == 0 && dec_valid && m_ewr && !rat_valid) m_mode = 1;
            else if (m_mode == 1 && rat_valid) m_mode = 0;
            else if (m_mode == 2) m_mode = 0;
         end
      end
   end

   // Applies one cycle of inputs just after a rising edge, then lets combinational paths settle.
   task automatic drive(input int v, input int wr, input int rd, input int rs1, input int rs2,
                        input int p1, input int p2, input int pw, input int tag,
                        input int rv, input int dr, input int fl);
      @(posedge clk);
      #1;
      dec_valid     = v[0];
      dec_wr        = wr[0];
      dec_rd        = rd[4:0];
      dec_rs1       = rs1[4:0];
      dec_rs2       = rs2[4:0];
      rat_phy_read1 = p1[5:0];
      rat_phy_read2 = p2[5:0];
      rat_phy_write = pw[5:0];
      dec_tag       = tag[7:0];
      rat_valid     = rv[0];
      dsp_ready     = dr[0];
      flush         = fl[0];
      #1;
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      check("rst_dsp_valid", 32'(dsp_valid), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_dsp_prd", 32'(dsp_prd), 32'd0);
      check("rst_dsp_tag", 32'(dsp_tag), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Three back-to-back allocating renames
      drive(1, 1, 1, 4, 5, 10, 11, 32, 1, 1, 1, 0);
      check("bb_regwrite0", 32'(rat_regwrite), 32'd1);
      drive(1, 1, 2, 1, 6, 32, 12, 33, 2, 1, 1, 0);
      check("bb_regwrite1", 32'(rat_regwrite), 32'd1);
      check("bb_prd0", 32'(dsp_prd), 32'd32);
      check("bb_prs1_0", 32'(dsp_prs1), 32'd10);
      drive(1, 1, 3, 2, 1, 33, 32, 34, 3, 1, 1, 0);
      check("bb_regwrite2", 32'(rat_regwrite), 32'd1);
      check("bb_prd1", 32'(dsp_prd), 32'd33);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("bb_prd2", 32'(dsp_prd), 32'd34);
      check("bb_tag2", 32'(dsp_tag), 32'd3);
      check("bb_valid2", 32'(dsp_valid), 32'd1);

      // Write to x0 never allocates
      drive(1, 1, 0, 3, 3, 34, 34, 50, 5, 1, 1, 0);
      check("x0_regwrite", 32'(rat_regwrite), 32'd0);
      check("x0_ready", 32'(dec_ready), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("x0_valid", 32'(dsp_valid), 32'd1);
      check("x0_wr", 32'(dsp_wr), 32'd0);
      check("x0_prd", 32'(dsp_prd), 32'd0);
      check("x0_tag", 32'(dsp_tag), 32'd5);

      // Free-list exhaustion stalls until rat_valid returns
      drive(1, 1, 7, 1, 2, 32, 33, 40, 7, 0, 1, 0);
      check("st_ready0", 32'(dec_ready), 32'd0);
      drive(1, 1, 7, 1, 2, 32, 33, 40, 7, 0, 1, 0);
      check("st_state", 32'(state), 32'd1);
      drive(1, 1, 7, 1, 2, 32, 33, 40, 7, 0, 1, 0);
      drive(1, 1, 7, 1, 2, 32, 33, 40, 7, 1, 1, 0);
      check("st_ready_in_stall", 32'(dec_ready), 32'd0);
      check("st_regwrite_in_stall", 32'(rat_regwrite), 32'd0);
      drive(1, 1, 7, 1, 2, 32, 33, 40, 7, 1, 1, 0);
      check("st_back_to_run", 32'(state), 32'd0);
      check("st_accept", 32'(rat_regwrite), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("st_prd", 32'(dsp_prd), 32'd40);
      check("st_tag", 32'(dsp_tag), 32'd7);
`ifdef RENAME_STALL_CNT_EN
      check("st_count", stall_cycles, 32'd4);
`endif

      // Dispatch backpressure holds the payload and blocks decode
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 9, 4, 4, 20, 21, 44, 9, 1, 0, 0);
         check("bp_ready", 32'(dec_ready), 32'd0);
         check("bp_regwrite", 32'(rat_regwrite), 32'd0);
         check("bp_prd_hold", 32'(dsp_prd), 32'd40);
         check("bp_tag_hold", 32'(dsp_tag), 32'd7);
         check("bp_valid_hold", 32'(dsp_valid), 32'd1);
      end
      drive(1, 1, 9, 4, 4, 20, 21, 44, 9, 1, 1, 0);
      check("bp_release_ready", 32'(dec_ready), 32'd1);
      check("bp_release_regwrite", 32'(rat_regwrite), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("bp_new_prd", 32'(dsp_prd), 32'd44);
      check("bp_new_prs2", 32'(dsp_prs2), 32'd21);

      // Flush beats a simultaneous accept
      drive(1, 1, 5, 1, 1, 2, 3, 45, 10, 1, 0, 1);
      check("fl_regwrite", 32'(rat_regwrite), 32'd0);
      check("fl_ready", 32'(dec_ready), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("fl_state", 32'(state), 32'd2);
      check("fl_valid", 32'(dsp_valid), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("fl_return", 32'(state), 32'd0);

      // Asynchronous reset pulse between edges
      drive(1, 1, 6, 3, 4, 7, 8, 46, 11, 1, 1, 0);
      check("ar_ready", 32'(dec_ready), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("ar_valid_before", 32'(dsp_valid), 32'd1);
      rst_pulses++;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("ar_valid_after", 32'(dsp_valid), 32'd0);
      check("ar_state_after", 32'(state), 32'd0);
      check("ar_prd_after", 32'(dsp_prd), 32'd0);

      // Replay after reset
      drive(1, 1, 1, 0, 0, 5, 6, 47, 12, 1, 1, 0);
      check("rp_regwrite", 32'(rat_regwrite), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("rp_prd", 32'(dsp_prd), 32'd47);
      check("rp_tag", 32'(dsp_tag), 32'd12);
      repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
